ifu_fetch_ctrl: RTL and testbench



---
 rtl/ifu_pkg.sv | 23 ++
 rtl/ifu_fetch_queue.sv | 55 +++++
 rtl/ifu_fetch_ctrl.sv | 93 +++++++++
 tb/tb_ifu_fetch_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the IFU fetch controller and its instruction queue.
package ifu_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_t;

    localparam logic [31:0] PC_INCR    = 32'd4;
    localparam int          FQ_ENTRY_W = 65;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        taken;
    } fq_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ifu_fetch_queue.sv
// Synchronous FIFO between fetch and decode: flush clears it outright,
// and the head is driven straight from the storage registers.
module ifu_fetch_queue #(
    parameter int DEPTH = 2,
    parameter int W     = 65
) (
    input  logic                         clock_in,
    input  logic                         reset_in,
    input  logic                         flush,
    input  logic                         push,
    input  logic [W-1:0]                 push_data,
    input  logic                         pop,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         head_valid,
    output logic [W-1:0]                 head_data
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic          full, do_push, do_pop;

    assign full       = (int'(count) == DEPTH);
    assign head_valid = (count != '0);
    assign do_pop     = head_valid && pop && !flush;
    // A pop in the same cycle frees the slot, so push-when-full is fine then.
    assign do_push    = push && !flush && (!full || do_pop);
    assign head_data  = head_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock_in) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// IFU fetch controller: single-outstanding imem handshake, predictor-steered
// next PC, execute redirects, and a small instruction queue toward decode.
module ifu_fetch_ctrl
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clock_in,
    input  logic        reset_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_gnt_in,
    input  logic        imem_rvalid_in,
    input  logic [31:0] imem_rdata_in,
    output logic [31:0] pred_pc_addr_out,
    output logic [31:0] pred_ins_data_out,
    input  logic        taken_pred_in,
    input  logic [31:0] pred_pc_in,
    input  logic        flush_in,
    input  logic [31:0] flush_pc_in,
    output logic        ins_valid_out,
    output logic [31:0] ins_data_out,
    output logic [31:0] ins_pc_out,
    output logic        ins_pred_taken_out,
    input  logic        ins_ready_in
);
    localparam int CW = $clog2(QUEUE_DEPTH+1);

    fetch_state_t state;
    logic [31:0]  fetch_pc, pend_pc;
    logic [CW-1:0] q_count;
    logic         can_issue, rsp_live, push;
    fq_entry_t    push_entry, head;

    // The in-flight word already owns a slot, so its push can never overflow.
    assign can_issue = (int'(q_count) + int'(state == S_WAIT)) < QUEUE_DEPTH;
    // Gated by reset so the port reads 0 while reset is held, not just after it.
    assign imem_req_out  = !reset_in && (state == S_REQ) && can_issue;
    assign imem_addr_out = reset_in ? '0 : fetch_pc;

    assign rsp_live          = (state == S_WAIT) && imem_rvalid_in;
    assign pred_pc_addr_out  = rsp_live ? pend_pc : '0;
    assign pred_ins_data_out = rsp_live ? imem_rdata_in : '0;
    assign push              = rsp_live && !flush_in;
    assign push_entry        = '{pc: pend_pc, ins: imem_rdata_in, taken: taken_pred_in};

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state    <= S_REQ;
            fetch_pc <= RESET_PC;
            pend_pc  <= '0;
        end else if (flush_in) begin
            fetch_pc <= word_align(flush_pc_in);
            case (state)
                S_REQ:   if (imem_req_out && imem_gnt_in) state <= S_DROP;
                S_WAIT:  state <= imem_rvalid_in ? S_REQ : S_DROP;
                S_DROP:  if (imem_rvalid_in) state <= S_REQ;
                default: state <= S_REQ;
            endcase
        end else begin
            case (state)
                S_REQ: if (imem_req_out && imem_gnt_in) begin
                    pend_pc <= fetch_pc;
                    state   <= S_WAIT;
                end
                S_WAIT: if (imem_rvalid_in) begin
                    fetch_pc <= taken_pred_in ? word_align(pred_pc_in) : pend_pc + PC_INCR;
                    state    <= S_REQ;
                end
                S_DROP:  if (imem_rvalid_in) state <= S_REQ;
                default: state <= S_REQ;
            endcase
        end
    end

    ifu_fetch_queue #(.DEPTH(QUEUE_DEPTH), .W(FQ_ENTRY_W)) u_queue (
        .clock_in   (clock_in),
        .reset_in   (reset_in),
        .flush      (flush_in),
        .push       (push),
        .push_data  (push_entry),
        .pop        (ins_ready_in),
        .count      (q_count),
        .head_valid (ins_valid_out),
        .head_data  (head)
    );

    assign ins_pc_out         = head.pc;
    assign ins_data_out       = head.ins;
    assign ins_pred_taken_out = head.taken;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Randomized bench for ifu_fetch_ctrl: a transaction-level model predicts
// fetch addresses and decoded words; a monitor checks every popped head.
module tb_ifu_fetch_ctrl;
    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0;

    logic        clock_in = 0, reset_in = 1;
    logic        imem_req_out, imem_gnt_in = 0, imem_rvalid_in = 0;
    logic [31:0] imem_addr_out, imem_rdata_in = 0;
    logic [31:0] pred_pc_addr_out, pred_ins_data_out, pred_pc_in = 0;
    logic        taken_pred_in = 0, flush_in = 0, ins_ready_in = 0;
    logic [31:0] flush_pc_in = 0;
    logic        ins_valid_out, ins_pred_taken_out;
    logic [31:0] ins_data_out, ins_pc_out;

    ifu_fetch_ctrl #(.RESET_PC(RST_PC), .QUEUE_DEPTH(DEPTH)) dut (
        .clock_in(clock_in), .reset_in(reset_in),
        .imem_req_out(imem_req_out), .imem_addr_out(imem_addr_out),
        .imem_gnt_in(imem_gnt_in), .imem_rvalid_in(imem_rvalid_in),
        .imem_rdata_in(imem_rdata_in),
        .pred_pc_addr_out(pred_pc_addr_out), .pred_ins_data_out(pred_ins_data_out),
        .taken_pred_in(taken_pred_in), .pred_pc_in(pred_pc_in),
        .flush_in(flush_in), .flush_pc_in(flush_pc_in),
        .ins_valid_out(ins_valid_out), .ins_data_out(ins_data_out),
        .ins_pc_out(ins_pc_out), .ins_pred_taken_out(ins_pred_taken_out),
        .ins_ready_in(ins_ready_in)
    );

    always #5 clock_in = ~clock_in;

    typedef struct { logic [31:0] pc; logic [31:0] ins; logic tk; } exp_t;
    exp_t        exp_q[$];
    logic [31:0] gnt_addrs[$], seen_pc[$];
    logic        seen_tk[$];
    int          total = 0, bad = 0, pop_cnt = 0;

    // Transaction-level model: next fetch address plus the one outstanding access.
    logic [31:0] exp_pc = RST_PC, txn_addr = 0;
    bit          busy = 0, drop = 0;
    int          delay = 0;

    int          p_gnt = 100, p_ready = 100, p_taken = 0, p_flush = 0, min_dly = 0, max_dly = 0;
    bit          use_fix = 0, flush_once = 0;
    logic [31:0] fix_pred = 0, flush_once_pc = 0;
    int          fl_idx = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, expv);
        end
    endtask

    task automatic cycle();
        bit ereq;
        @(posedge clock_in); #1;
        ereq = !busy && (exp_q.size() < DEPTH);
        chk("req", imem_req_out, ereq);
        if (!busy) chk("addr", imem_addr_out, exp_pc);
        chk("addr_lsb", {30'b0, imem_addr_out[1:0]}, 0);
        chk("ins_valid", ins_valid_out, exp_q.size() != 0);

        imem_gnt_in    = ereq && ($urandom_range(99) < p_gnt);
        imem_rvalid_in = busy && (delay == 0);
        if (imem_rvalid_in) begin
            imem_rdata_in = $urandom();
            taken_pred_in = $urandom_range(99) < p_taken;
            pred_pc_in    = use_fix ? fix_pred : ($urandom() & 32'hFFFF_FFFC);
        end else begin
            imem_rdata_in = 0; taken_pred_in = 0; pred_pc_in = 0;
        end
        ins_ready_in = $urandom_range(99) < p_ready;
        flush_in = 0;
        if (flush_once && busy && !drop && !imem_rvalid_in) begin
            flush_in = 1; flush_pc_in = flush_once_pc; flush_once = 0;
            fl_idx = gnt_addrs.size();
        end else if ($urandom_range(99) < p_flush) begin
            flush_in = 1; flush_pc_in = $urandom();
        end
        if (imem_gnt_in) gnt_addrs.push_back(imem_addr_out);

        @(negedge clock_in);
        if (imem_rvalid_in) begin
            if (!drop) begin
                chk("pred_pc", pred_pc_addr_out, txn_addr);
                chk("pred_ins", pred_ins_data_out, imem_rdata_in);
                if (!flush_in) begin
                    exp_q.push_back('{pc: txn_addr, ins: imem_rdata_in, tk: taken_pred_in});
                    exp_pc = taken_pred_in ? pred_pc_in : txn_addr + 32'd4;
                end
            end
            busy = 0;
        end else begin
            chk("pred_pc_idle", pred_pc_addr_out, 0);
            chk("pred_ins_idle", pred_ins_data_out, 0);
            if (busy) delay--;
        end
        if (imem_gnt_in) begin
            busy = 1; drop = 0; txn_addr = exp_pc;
            delay = min_dly + $urandom_range(max_dly - min_dly);
        end
        if (flush_in) begin
            exp_q.delete();
            exp_pc = flush_pc_in & 32'hFFFF_FFFC;
            if (busy) drop = 1;
        end
    endtask

    always @(negedge clock_in) begin : monitor
        exp_t e;
        if (!reset_in && ins_valid_out && ins_ready_in && !flush_in) begin
            pop_cnt++;
            seen_pc.push_back(ins_pc_out);
            seen_tk.push_back(ins_pred_taken_out);
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL pop_empty: got pc %h want no entry", ins_pc_out);
            end else begin
                e = exp_q.pop_front();
                chk("head_pc", ins_pc_out, e.pc);
                chk("head_ins", ins_data_out, e.ins);
                chk("head_tk", ins_pred_taken_out, e.tk);
            end
        end
    end

    task automatic chk_gnt(input string name, input int idx, input logic [31:0] want);
        if (idx >= 0 && idx < gnt_addrs.size()) chk(name, gnt_addrs[idx], want);
        else begin total++; bad++; $display("FAIL %s: got no grant %0d want %h", name, idx, want); end
    endtask

    task automatic idle_zero_checks(input string tag);
        chk({tag, "_req"}, imem_req_out, 0);
        chk({tag, "_addr"}, imem_addr_out, 0);
        chk({tag, "_ppc"}, pred_pc_addr_out, 0);
        chk({tag, "_pins"}, pred_ins_data_out, 0);
        chk({tag, "_valid"}, ins_valid_out, 0);
        chk({tag, "_ipc"}, ins_pc_out, 0);
        chk({tag, "_idata"}, ins_data_out, 0);
        chk({tag, "_itk"}, ins_pred_taken_out, 0);
    endtask

    initial begin
        logic [31:0] seq_a [6];
        int g0, pc0, n;
        bit hit;
        seq_a = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h40};

        @(negedge clock_in);
        idle_zero_checks("rst");
        @(negedge clock_in);
        reset_in = 0;

        // Sequential fetch; the word at 0x10 is predicted taken to 0x40.
        use_fix = 1; fix_pred = 32'h40;
        for (int i = 0; i < 40 && gnt_addrs.size() < 6; i++) begin
            cycle();
            p_taken = (gnt_addrs.size() == 5) ? 100 : 0;
        end
        p_taken = 0;
        repeat (4) cycle();
        for (int i = 0; i < 6; i++) chk_gnt("seq_gnt", i, seq_a[i]);
        for (int i = 0; i < 5; i++)
            if (i < seen_pc.size()) chk("seq_pop_pc", seen_pc[i], seq_a[i]);
            else begin total++; bad++; $display("FAIL seq_pop_pc: got none want %h", seq_a[i]); end
        if (seen_tk.size() >= 5) begin
            chk("seq_tk_c", seen_tk[3], 0);
            chk("seq_tk_10", seen_tk[4], 1);
        end else begin total++; bad++; $display("FAIL seq_tk: got %0d pops want 5", seen_tk.size()); end

        // Backpressure fills the queue; a single ready cycle admits exactly one refetch.
        p_ready = 0;
        repeat (12) cycle();
        chk("bp_req", imem_req_out, 0);
        chk("bp_valid", ins_valid_out, 1);
        g0 = gnt_addrs.size(); pc0 = pop_cnt;
        p_ready = 100; cycle(); p_ready = 0;
        repeat (6) cycle();
        chk("bp_one_gnt", gnt_addrs.size() - g0, 1);
        chk("bp_one_pop", pop_cnt - pc0, 1);

        // Flush while waiting with a queued word: redirect to 0x200, drop the late word.
        min_dly = 1; max_dly = 2;
        flush_once = 1; flush_once_pc = 32'h203;
        p_ready = 100; cycle(); p_ready = 0;
        repeat (10) cycle();
        chk_gnt("flush_gnt", fl_idx, 32'h200);

        // Address wrap past the top of memory.
        p_ready = 100; flush_once = 1; flush_once_pc = 32'hFFFF_FFFC;
        repeat (15) cycle();
        chk_gnt("wrap_gnt0", fl_idx, 32'hFFFF_FFFC);
        chk_gnt("wrap_gnt1", fl_idx + 1, 32'h0);

        // Reset pulsed in the middle of an outstanding access.
        min_dly = 2; max_dly = 3; hit = 0;
        for (n = 0; n < 20 && !hit; n++) begin
            cycle();
            hit = busy && !drop;
        end
        if (!hit) begin total++; bad++; $display("FAIL rst_wait: got no S_WAIT want one"); end
        imem_gnt_in = 0; imem_rvalid_in = 0; flush_in = 0; ins_ready_in = 0;
        #2 reset_in = 1;
        #1 idle_zero_checks("midrst");
        exp_q.delete(); busy = 0; drop = 0; exp_pc = RST_PC;
        @(posedge clock_in); @(posedge clock_in); @(negedge clock_in);
        reset_in = 0;
        min_dly = 0; max_dly = 0;
        cycle();

        // Random traffic, knobs reshuffled every 100 cycles.
        use_fix = 0;
        for (int b = 0; b < 30; b++) begin
            p_gnt = $urandom_range(100, 30); p_ready = $urandom_range(100, 20);
            p_taken = $urandom_range(60); p_flush = $urandom_range(8);
            min_dly = 0; max_dly = $urandom_range(4);
            repeat (100) cycle();
        end
        chk("pops_seen", pop_cnt > 200, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
